// File: rtl/sync_fifo_pkg.sv
// Shared defaults and request encoding for the single-clock FWFT FIFO.
package sync_fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 255;

  // {pop_accepted, push_accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } op_e;
endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo: master is the client side, slave is the FIFO.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;

  modport master (output din, push, pop, input dout, full, empty);
  modport slave  (input din, push, pop, output dout, full, empty);
endinterface

// File: rtl/sync_fifo_mem.sv
// DATA_WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 255,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  // No reset on storage so it can map onto distributed RAM.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO control: pointers, occupancy count and flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        resetn,
  sync_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push_ok, w_pop_ok;
  logic [DATA_WIDTH-1:0] w_rdata;
  op_e                   w_op;

  // Wrap at DEPTH-1 explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign bus.full  = (r_count == CW'(DEPTH));
  assign bus.empty = (r_count == '0);

  // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
  assign w_push_ok = bus.push && !bus.full;
  assign w_pop_ok  = bus.pop  && !bus.empty;
  assign w_op      = op_e'({w_pop_ok, w_push_ok});

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case (w_op)
        OP_PUSH: r_count <= r_count + CW'(1);
        OP_POP:  r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.dout = w_rdata;
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 255;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] q[$];

  sync_fifo_if #(.DATA_WIDTH(DW)) bus();

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of requests, advance the model by the FIFO's rules, sample 1ns after the edge.
  task automatic tick(input logic p, input logic r, input logic [DW-1:0] d);
    bit pa, ra;
    bus.push = p; bus.pop = r; bus.din = d;
    if (!resetn) q.delete();
    else begin
      pa = p && (q.size() < DEPTH);
      ra = r && (q.size() > 0);
      if (ra) void'(q.pop_front());
      if (pa) q.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(0, 0, '0); tick(0, 0, '0);
    resetn = 1'b1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    tick(0, 1, '0);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL pop_on_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp;
    tick(1, 0, 8'h41);
    checks++; if (bus.dout !== 8'h41) begin errors++; $display("FAIL first_word dout got %h want 41", bus.dout); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL first_word empty got %b want 0", bus.empty); end
    tick(1, 0, 8'h42);
    tick(1, 0, 8'h43);
    for (int i = 0; i < 3; i++) begin
      exp = 8'(8'h41 + i);
      checks++; if (bus.dout !== exp) begin errors++; $display("FAIL basic_pop%0d got %h want %h", i, bus.dout, exp); end
      tick(0, 1, '0);
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_drained empty got %b want 1", bus.empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) tick(1, 0, 8'(i));
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.full); end
    tick(1, 0, 8'hFF);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL overflow_full got %b want 1", bus.full); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bus.dout !== 8'(i) || bus.empty !== 1'b0) begin
        errors++; $display("FAIL drain[%0d] dout %h empty %b want %h 0", i, bus.dout, bus.empty, 8'(i));
      end
      tick(0, 1, '0);
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d;
    for (int k = 0; k < 600; k++) begin
      if (k % 2 == 0) begin
        d = 8'($urandom);
        tick(1, 0, d);
        checks++;
        if (bus.dout !== d || bus.empty !== 1'b0 || bus.full !== 1'b0) begin
          errors++; $display("FAIL wrap_push k=%0d dout %h empty %b full %b want %h 0 0", k, bus.dout, bus.empty, bus.full, d);
        end
      end else begin
        tick(0, 1, '0);
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
          errors++; $display("FAIL wrap_pop k=%0d empty %b full %b want 1 0", k, bus.empty, bus.full);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int n;
    tick(1, 1, 8'h77);
    checks++; if (bus.empty !== 1'b0 || bus.dout !== 8'h77) begin
      errors++; $display("FAIL pp_empty empty %b dout %h want 0 77", bus.empty, bus.dout); end
    for (int i = 0; i < 4; i++) tick(1, 0, 8'(8'h10 + i));
    tick(1, 1, 8'h99);
    checks++; if (bus.dout !== 8'h10) begin errors++; $display("FAIL pp_five dout got %h want 10", bus.dout); end
    n = 0;
    while (bus.empty === 1'b0 && n < 10) begin
      checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL pp_five_drain dout %h want %h", bus.dout, q[0]); end
      tick(0, 1, '0); n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL pp_five_count got %0d want 5", n); end
    for (int i = 0; i < DEPTH; i++) tick(1, 0, 8'($urandom));
    tick(1, 1, 8'hEE);
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL pp_full full got %b want 0", bus.full); end
    checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL pp_full dout %h want %h", bus.dout, q[0]); end
    tick(1, 0, 8'h3C);
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL pp_full_refill full got %b want 1", bus.full); end
    while (q.size() > 0) begin
      checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL pp_full_drain dout %h want %h", bus.dout, q[0]); end
      tick(0, 1, '0);
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL pp_full_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 10; i++) tick(1, 0, 8'($urandom));
    resetn = 1'b0;
    tick(1, 0, 8'hA5);
    resetn = 1'b1;
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      errors++; $display("FAIL midreset empty %b full %b want 1 0", bus.empty, bus.full); end
    tick(1, 0, 8'h5A);
    checks++; if (bus.dout !== 8'h5A || bus.empty !== 1'b0) begin
      errors++; $display("FAIL midreset_push dout %h empty %b want 5a 0", bus.dout, bus.empty); end
    tick(0, 1, '0);
  endtask

  task automatic test_random();
    int pct;
    logic p, r;
    for (int k = 0; k < 2000; k++) begin
      pct = ((k / 500) % 2 == 0) ? 80 : 20;
      p = ($urandom_range(99) < pct);
      r = ($urandom_range(99) < (100 - pct));
      if (q.size() > 0) begin
        checks++; if (bus.dout !== q[0]) begin errors++; $display("FAIL rand_dout k=%0d got %h want %h", k, bus.dout, q[0]); end
      end
      tick(p, r, 8'($urandom));
      checks++;
      if (bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH)) begin
        errors++; $display("FAIL rand_flags k=%0d empty %b full %b want %b %b", k, bus.empty, bus.full,
                          q.size() == 0, q.size() == DEPTH);
      end
    end
  endtask

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0;
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_simultaneous();
    test_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
